hwpe_ctrl_uloop: RTL

HWPE_CTRL_ULOOP -- requirements
Module: hwpe_ctrl_uloop

---
 rtl/hwpe_ctrl_package.sv | 47 ++++
 rtl/hwpe_ctrl_uloop_lvl_sel.sv | 34 +++
 rtl/hwpe_ctrl_uloop.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_package.sv
// Shared microcode loop types and default sizing for the HWPE controller.
// The loop sequencer and its testbench both build on these definitions.
package hwpe_ctrl_package;

    localparam int UCODE_NB_LOOPS  = 6;
    localparam int UCODE_LENGTH    = 17;
    localparam int UCODE_NB_REG    = 4;
    localparam int UCODE_NB_RO_REG = 28;
    localparam int UCODE_CNT_WIDTH = 12;

    // One microcode op: R[a] += (op_sel ? RO[b] : R[b]).
    typedef struct packed {
        logic       op_sel;
        logic [4:0] a;
        logic [4:0] b;
    } ucode_op_t;

    typedef struct packed {
        logic [4:0] ucode_addr;
        logic [4:0] nb_ops;
    } ucode_loop_t;

    typedef ucode_loop_t [UCODE_NB_LOOPS-1:0]                     ucode_loops_t;
    typedef ucode_op_t   [UCODE_LENGTH-1:0]                       ucode_code_t;
    typedef logic        [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] ucode_range_t;

    typedef struct packed {
        ucode_loops_t loops;
        ucode_code_t  code;
        ucode_range_t range;
    } ucode_t;

    typedef struct packed {
        logic       enable;
        logic       clear;
        logic [2:0] accum_loop;
    } ctrl_ucode_t;

    typedef struct packed {
        logic                           done;
        logic                           valid;
        logic [UCODE_NB_REG-1:0][31:0] offs;
        ucode_range_t                   idx;
        logic                           accum;
    } flags_ucode_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_lvl_sel.sv
// Picks the innermost loop level that still has iterations left, and flags
// when every level has reached its last index.
module hwpe_ctrl_uloop_lvl_sel #(
    parameter int NB_LOOPS  = 6,
    parameter int CNT_WIDTH = 12,
    parameter int LVL_W     = 3
) (
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] i_idx,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] i_range,
    output logic [LVL_W-1:0]                   o_lvl,
    output logic                               o_all_end
);

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] w_last;

    // A zero range behaves as a single-iteration loop.
    for (genvar k = 0; k < NB_LOOPS; k++) begin : g_last
        assign w_last[k] = (i_range[k] == '0) ? '0 : i_range[k] - ONE;
    end

    always_comb begin
        o_lvl     = '0;
        o_all_end = 1'b1;
        for (int k = NB_LOOPS - 1; k >= 0; k--) begin
            if (i_idx[k] < w_last[k]) begin
                o_lvl     = LVL_W'(k);
                o_all_end = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_uloop.sv
// Nested-loop microcode sequencer: walks the loop index space and, between
// iterations, runs the owning level's ops to update the offset registers.
module hwpe_ctrl_uloop
    import hwpe_ctrl_package::*;
#(
    parameter int NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int LENGTH    = UCODE_LENGTH,
    parameter int NB_REG    = UCODE_NB_REG,
    parameter int NB_RO_REG = UCODE_NB_RO_REG,
    parameter int CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        clear_i,
    input  ctrl_ucode_t                 ctrl_i,
    output flags_ucode_t                flags_o,
    input  ucode_t                      uloop_code_i,
    input  logic [NB_RO_REG-1:0][31:0]  registers_read_i
);

    localparam int LVL_W = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;
    localparam int REG_W = (NB_REG > 1) ? $clog2(NB_REG) : 1;
    localparam logic [5:0]           LEN_C = 6'(LENGTH);
    localparam logic [4:0]           NREG_C = 5'(NB_REG);
    localparam logic [4:0]           NRO_C = 5'(NB_RO_REG);
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_EXEC, ST_DONE} state_t;

    state_t                             r_state, w_state_nxt;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] r_idx;
    logic [NB_REG-1:0][31:0]            r_regs;
    logic [4:0]                         r_opcnt;
    logic [LVL_W-1:0]                   r_lvl;

    logic [LVL_W-1:0] w_lvl;
    logic             w_all_end;
    logic             w_clear;
    logic             w_advance;
    logic             w_last_op;
    logic [5:0]       w_addr;
    logic             w_op_ok;
    ucode_op_t        w_op;
    logic [31:0]      w_opnd_b;
    logic             w_accum;

    hwpe_ctrl_uloop_lvl_sel #(
        .NB_LOOPS  (NB_LOOPS),
        .CNT_WIDTH (CNT_WIDTH),
        .LVL_W     (LVL_W)
    ) i_lvl_sel (
        .i_idx     (r_idx),
        .i_range   (uloop_code_i.range),
        .o_lvl     (w_lvl),
        .o_all_end (w_all_end)
    );

    assign w_clear   = clear_i | ctrl_i.clear;
    assign w_advance = (r_state == ST_VALID) && ctrl_i.enable && !w_all_end;
    assign w_last_op = (r_opcnt == uloop_code_i.loops[r_lvl].nb_ops - 5'd1);

    // Ops past the end of the code store are NOPs but still consume a cycle.
    assign w_addr  = {1'b0, uloop_code_i.loops[r_lvl].ucode_addr} + {1'b0, r_opcnt};
    assign w_op_ok = (w_addr < LEN_C);
    assign w_op    = w_op_ok ? uloop_code_i.code[w_addr[4:0]] : '0;

    always_comb begin
        w_opnd_b = '0;
        if (w_op.op_sel) begin
            if (w_op.b < NRO_C) w_opnd_b = registers_read_i[w_op.b];
        end else begin
            if (w_op.b < NREG_C) w_opnd_b = r_regs[w_op.b[REG_W-1:0]];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (ctrl_i.enable) w_state_nxt = ST_VALID;
            ST_VALID: begin
                if (ctrl_i.enable) begin
                    if (w_all_end)
                        w_state_nxt = ST_DONE;
                    else if (uloop_code_i.loops[w_lvl].nb_ops == '0)
                        w_state_nxt = ST_VALID;
                    else
                        w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC:  if (w_last_op) w_state_nxt = ST_VALID;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_regs  <= '0;
            r_opcnt <= '0;
            r_lvl   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                for (int k = 0; k < NB_LOOPS; k++) begin
                    if (LVL_W'(k) == w_lvl)
                        r_idx[k] <= r_idx[k] + ONE;
                    else if (LVL_W'(k) < w_lvl)
                        r_idx[k] <= '0;
                end
                r_lvl   <= w_lvl;
                r_opcnt <= '0;
            end
            if (r_state == ST_EXEC) begin
                r_opcnt <= r_opcnt + 5'd1;
                if (w_op_ok && (w_op.a < NREG_C))
                    r_regs[w_op.a[REG_W-1:0]] <= r_regs[w_op.a[REG_W-1:0]] + w_opnd_b;
            end
        end
    end

    // Accumulate is off only while every level inside accum_loop sits at 0.
    always_comb begin
        w_accum = 1'b0;
        for (int k = 0; k < NB_LOOPS; k++) begin
            if ((k < int'(ctrl_i.accum_loop)) && (r_idx[k] != '0)) w_accum = 1'b1;
        end
    end

    always_comb begin
        flags_o       = '0;
        flags_o.done  = (r_state == ST_DONE);
        flags_o.valid = (r_state == ST_VALID);
        flags_o.offs  = r_regs;
        flags_o.idx   = r_idx;
        flags_o.accum = w_accum;
    end

endmodule
